// File: rtl/cnt_pkg.sv
// Shared constants for the cascaded up/down digit counter.
package cnt_pkg;
  localparam int DW = 4;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/bcd_digit_stage.sv
// One modulo-MOD up/down digit; load has priority over the count enable.
module bcd_digit_stage
  import cnt_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          EN,
  input  logic          UP,
  input  logic          LD,
  input  logic [DW-1:0] DIN,
  output logic [DW-1:0] Q,
  output logic          TC
);
  localparam logic [DW-1:0] MAXV = DW'(MOD - 1);

  // Out-of-range load digits saturate to the top code.
  logic [DW-1:0] din_c;
  assign din_c = (DIN > MAXV) ? MAXV : DIN;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)     Q <= '0;
    else if (LD) Q <= din_c;
    else if (EN) begin
      if (UP == DIR_UP) Q <= (Q == MAXV) ? '0 : Q + DW'(1);
      else              Q <= (Q == '0) ? MAXV : Q - DW'(1);
    end
  end

  assign TC = (UP == DIR_UP) ? (Q == MAXV) : (Q == '0);
endmodule

// File: rtl/bcd_updown_chain.sv
// Synchronous N-digit up/down counter: digit carries are count enables, not clocks.
module bcd_updown_chain
  import cnt_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int MOD    = 10
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               CE,
  input  logic               UP,
  input  logic               LD,
  input  logic [DW*DIGITS-1:0] D,
  output logic [DW*DIGITS-1:0] Q,
  output logic               CEO,
  output logic               TC_R
);
  logic [DIGITS:0]   en;
  logic [DIGITS-1:0] tc;

  assign en[0] = CE & ~LD & ~CLR;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_stage #(.MOD(MOD)) u_dig (
      .CLK (CLK),
      .CLR (CLR),
      .EN  (en[i]),
      .UP  (UP),
      .LD  (LD),
      .DIN (D[DW*i +: DW]),
      .Q   (Q[DW*i +: DW]),
      .TC  (tc[i])
    );
    assign en[i+1] = en[i] & tc[i];
  end

  assign CEO = en[DIGITS];

  // Pulse lands with the wrapped count since CEO is sampled at the wrap edge.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) TC_R <= 1'b0;
    else     TC_R <= CEO;
  end
endmodule

// File: tb/tb_bcd_updown_chain.sv
// Self-checking bench for a 2-digit decimal chain against an integer reference model.
module tb_bcd_updown_chain;
  logic       CLK, CLR, CE, UP, LD;
  logic [7:0] D, Q;
  logic       CEO, TC_R;

  bcd_updown_chain #(.DIGITS(2), .MOD(10)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .UP(UP), .LD(LD),
    .D(D), .Q(Q), .CEO(CEO), .TC_R(TC_R)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] q;
    logic       tcr;
  } exp_t;
  exp_t sb[$];

  int nvec = 0;
  int nerr = 0;
  int mv   = 0;
  logic mtcr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clamp(input logic [7:0] d);
    int hi, lo;
    hi = (d[7:4] > 4'd9) ? 9 : int'(d[7:4]);
    lo = (d[3:0] > 4'd9) ? 9 : int'(d[3:0]);
    return hi * 10 + lo;
  endfunction

  // Called just after an edge; returns just after the next edge.
  task automatic step(input logic clr, input logic ce, input logic up,
                      input logic ld, input logic [7:0] d);
    exp_t e;
    logic ceo_x;
    CLR = clr; CE = ce; UP = up; LD = ld; D = d;
    #1;
    ceo_x = !clr && ce && !ld && (up ? (mv == 99) : (mv == 0));
    chk("ceo", {31'd0, CEO}, {31'd0, ceo_x});
    if (clr) begin
      mv = 0; mtcr = 1'b0;
    end else begin
      if (ld)      mv = clamp(d);
      else if (ce) mv = up ? (mv + 1) % 100 : (mv + 99) % 100;
      mtcr = ceo_x;
    end
    e.q = bcd(mv); e.tcr = mtcr;
    sb.push_back(e);
    @(posedge CLK); #1;
    e = sb.pop_front();
    chk("q", {24'd0, Q}, {24'd0, e.q});
    chk("tcr", {31'd0, TC_R}, {31'd0, e.tcr});
  endtask

  task automatic peek_ceo(input logic ce, input logic up, input logic exp);
    CE = ce; UP = up; LD = 1'b0;
    #1;
    chk("ceo_peek", {31'd0, CEO}, {31'd0, exp});
  endtask

  // Asynchronous clear pulse entirely between edges.
  task automatic clr_pulse();
    CE = 1'b1; UP = 1'b1; LD = 1'b0; CLR = 1'b1;
    #1;
    chk("clr_q", {24'd0, Q}, 32'd0);
    chk("clr_tcr", {31'd0, TC_R}, 32'd0);
    chk("clr_ceo", {31'd0, CEO}, 32'd0);
    CLR = 1'b0;
    mv = 0; mtcr = 1'b0;
    #1;
  endtask

  initial begin
    CLR = 1'b1; CE = 1'b1; UP = 1'b1; LD = 1'b0; D = 8'h00;
    @(posedge CLK); #1;
    chk("rst_q", {24'd0, Q}, 32'd0);
    chk("rst_tcr", {31'd0, TC_R}, 32'd0);
    chk("rst_ceo", {31'd0, CEO}, 32'd0);
    CLR = 1'b0;

    // 1: full up count and wrap
    step(0, 0, 1, 1, 8'h37);
    clr_pulse();
    for (int i = 0; i < 99; i++) step(0, 1, 1, 0, 8'h00);
    peek_ceo(1, 1, 1'b1);
    step(0, 1, 1, 0, 8'h00);
    step(0, 0, 1, 0, 8'h00);

    // 2: CE gating from 00
    clr_pulse();
    for (int i = 0; i < 20; i++) step(0, i[0] == 0, 1, 0, 8'h00);

    // 3: load then count down through the wrap
    step(0, 0, 1, 1, 8'h10);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 8'h00);
    peek_ceo(1, 0, 1'b1);
    step(0, 1, 0, 0, 8'h00);

    // 4: load clamp beats CE; clear beats load
    step(0, 1, 1, 1, 8'hF3);
    step(1, 1, 1, 1, 8'hF3);

    // 5: direction flip at the top boundary
    step(0, 0, 1, 1, 8'h99);
    peek_ceo(1, 1, 1'b1);
    step(0, 1, 0, 0, 8'h00);

    // 6: async clear mid-count, then resume from zero
    clr_pulse();
    for (int i = 0; i < 47; i++) step(0, 1, 1, 0, 8'h00);
    clr_pulse();
    step(0, 1, 1, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
